// File: rtl/memwb_elastic_reg_pkg.sv
// ----------------------------------------------------------------------------
// memwb_elastic_reg_pkg
//   Shared types for the MEM/WB elastic boundary.
//   - Load funct3 encodings (RISC-V I/RV64I load group).
//   - entry_t: one buffered writeback entry {data, rd, regwrite}. Fields are
//     sized to the widest supported configuration; the top zero-extends into
//     them and slices back out, so a single struct serves XLEN=32/64 and any
//     RA_W up to RA_W_MAX.
//   - occ_e: occupancy of the two-entry (main + skid) buffer.
// ----------------------------------------------------------------------------
package memwb_elastic_reg_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] LWU = 3'd6;

  localparam int XLEN_MAX = 64;
  localparam int RA_W_MAX = 8;

  typedef struct packed {
    logic [XLEN_MAX-1:0] data;
    logic [RA_W_MAX-1:0] rd;
    logic                regwrite;
  } entry_t;

  // EMPTY: nothing buffered; ONE: main valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/memwb_elastic_reg_align.sv
// ----------------------------------------------------------------------------
// load_align_ext
//   Combinational load-data alignment and sign/zero extension.
//   Ports:
//     rdata  in  XLEN   raw memory read word
//     offset in  OFF_W  byte offset inside the word (low ALU result bits)
//     funct3 in  3      load type
//     ext    out XLEN   aligned, extended load value
//   Misaligned half/word offsets are truncated to natural alignment. LD on a
//   32-bit datapath behaves as LW. The unused encoding 7 passes rdata through.
// ----------------------------------------------------------------------------
module load_align_ext
  import memwb_elastic_reg_pkg::*;
#(
  parameter  int XLEN  = 64,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  ext
);

  localparam bit HAS_LD = (XLEN == 64);

  logic [OFF_W-1:0] align_off;
  logic [XLEN-1:0]  shifted;

  // Natural alignment: clear the low offset bits for the access size.
  always_comb begin
    align_off = offset;
    case (funct3)
      LB, LBU: align_off = offset;
      LH, LHU: align_off = offset & ~OFF_W'(1);
      LW, LWU: align_off = offset & ~OFF_W'(3);
      default: align_off = '0;
    endcase
  end

  assign shifted = rdata >> {align_off, 3'b000};

  always_comb begin
    ext = rdata;
    case (funct3)
      LB:      ext = XLEN'($signed(shifted[7:0]));
      LH:      ext = XLEN'($signed(shifted[15:0]));
      LW:      ext = XLEN'($signed(shifted[31:0]));
      LD:      ext = HAS_LD ? rdata : XLEN'($signed(shifted[31:0]));
      LBU:     ext = XLEN'(shifted[7:0]);
      LHU:     ext = XLEN'(shifted[15:0]);
      LWU:     ext = XLEN'(shifted[31:0]);
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/memwb_elastic_reg.sv
// ----------------------------------------------------------------------------
// memwb_elastic_reg
//   MEM/WB pipeline boundary with valid/ready on both sides and a two-entry
//   (main + skid) buffer so that in_ready is a register, never a combinational
//   function of out_ready. The writeback value (load data aligned/extended or
//   ALU result) is formed before capture.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     in_valid / in_ready        MEM-side handshake (in_ready registered)
//     read_data_in               raw memory word
//     result_alu_in              ALU result; low bits are the load byte offset
//     ld_funct3_in               load type
//     rd_in, memtoreg_in,
//     regwrite_in                destination, load-select, write enable
//     flush                      drop all buffered entries and same-cycle input
//     out_valid / out_ready      WB-side handshake
//     wb_data, wb_rd,
//     wb_regwrite                head entry payload (held while empty)
//     fwd_valid                  out_valid & wb_regwrite for forwarding
//     retired                    output fires, wraps modulo 2^RET_W
// ----------------------------------------------------------------------------
module memwb_elastic_reg
  import memwb_elastic_reg_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  read_data_in,
  input  logic [XLEN-1:0]  result_alu_in,
  input  logic [2:0]       ld_funct3_in,
  input  logic [RA_W-1:0]  rd_in,
  input  logic             memtoreg_in,
  input  logic             regwrite_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [RA_W-1:0]  wb_rd,
  output logic             wb_regwrite,
  output logic             fwd_valid,
  output logic [RET_W-1:0] retired
);

  localparam int OFF_W = $clog2(XLEN/8);

  occ_e             state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           cap;
  logic             in_ready_q, in_ready_d;
  logic [RET_W-1:0] retired_q;
  logic [XLEN-1:0]  ext;
  logic             in_fire, out_fire;

  load_align_ext #(.XLEN(XLEN)) u_align (
    .rdata  (read_data_in),
    .offset (result_alu_in[OFF_W-1:0]),
    .funct3 (ld_funct3_in),
    .ext    (ext)
  );

  // Entry as it would be captured this cycle. x0 writes are suppressed here
  // so the forwarding unit never sees a bogus x0 producer.
  always_comb begin
    cap          = '0;
    cap.data     = XLEN_MAX'(memtoreg_in ? ext : result_alu_in);
    cap.rd       = RA_W_MAX'(rd_in);
    cap.regwrite = regwrite_in & (rd_in != '0);
  end

  assign out_valid = (state_q != OCC_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // Occupancy FSM. Main is always the head; skid only ever holds the entry
  // behind it, which keeps ordering strictly FIFO.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_d  = cap;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_d = cap;
          end else if (in_fire) begin
            skid_d  = cap;
            state_d = OCC_FULL;
          end else if (out_fire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so in_fire is normally 0; the refill path
          // is kept so the buffer stays correct if that ever changes.
          if (out_fire) begin
            main_d = skid_q;
            if (in_fire) skid_d = cap;
            else         state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
    in_ready_d = (state_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OCC_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      // A fire that coincides with flush is discarded, so it is not retired.
      if (out_fire && !flush) retired_q <= retired_q + RET_W'(1);
    end
  end

  assign in_ready    = in_ready_q;
  assign wb_data     = main_q.data[XLEN-1:0];
  assign wb_rd       = main_q.rd[RA_W-1:0];
  assign wb_regwrite = main_q.regwrite;
  assign fwd_valid   = out_valid & main_q.regwrite;
  assign retired     = retired_q;

  // Upper struct bits beyond XLEN/RA_W are always zero and never read.
  logic unused_hi;
  assign unused_hi = ^{main_q.data, main_q.rd};

endmodule

// File: tb/tb_memwb_elastic_reg.sv
module tb_memwb_elastic_reg;

  localparam int XLEN  = 64;
  localparam int RA_W  = 5;
  localparam int RET_W = 4;

  localparam logic [63:0] DW = 64'h8899AABB_CCDDEEFF;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  read_data_in;
  logic [XLEN-1:0]  result_alu_in;
  logic [2:0]       ld_funct3_in;
  logic [RA_W-1:0]  rd_in;
  logic             memtoreg_in;
  logic             regwrite_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  wb_data;
  logic [RA_W-1:0]  wb_rd;
  logic             wb_regwrite;
  logic             fwd_valid;
  logic [RET_W-1:0] retired;

  memwb_elastic_reg #(.XLEN(XLEN), .RA_W(RA_W), .RET_W(RET_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .read_data_in(read_data_in), .result_alu_in(result_alu_in),
    .ld_funct3_in(ld_funct3_in), .rd_in(rd_in), .memtoreg_in(memtoreg_in),
    .regwrite_in(regwrite_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .fwd_valid(fwd_valid), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever WB consumes an entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (flush) begin
        q.delete();
      end else if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got data %h rd %0d with nothing expected", wb_data, wb_rd);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_data", 64'(wb_data), e.d);
          chk("wb_rd", 64'(wb_rd), 64'(e.rd));
          chk("wb_regwrite", 64'(wb_regwrite), 64'(e.we));
          chk("fwd_valid", 64'(fwd_valid), 64'(e.we));
        end
      end
    end
  end

  // Present one instruction and hold it until accepted; the expected
  // writeback entry is queued at acceptance.
  task automatic send(input logic [63:0] rdat, input logic [63:0] alu,
                      input logic [2:0] f3, input logic [4:0] rd,
                      input logic m2r, input logic rw,
                      input logic [63:0] ed, input logic ewe);
    exp_t e;
    bit   acc;
    acc           = 1'b0;
    read_data_in  = rdat;
    result_alu_in = alu;
    ld_funct3_in  = f3;
    rd_in         = rd;
    memtoreg_in   = m2r;
    regwrite_in   = rw;
    in_valid      = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.d  = ed;
        e.rd = rd;
        e.we = ewe;
        q.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no in_ready expected accept for rd %0d", rd);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    read_data_in = '0; result_alu_in = '0; ld_funct3_in = '0;
    rd_in = '0; memtoreg_in = 1'b0; regwrite_in = 1'b0;

    // Reset held two cycles.
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_regwrite", 64'(wb_regwrite), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_release_cycle", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_after_release", 64'(in_ready), 64'd1);
    chk("retired_after_reset", 64'(retired), 64'd0);
    @(posedge clk); #1;

    // LB offset 1 -> sign-extended 0x80; one-cycle latency.
    send(64'h80FF, 64'h1001, 3'd0, 5'd5, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFF80, 1'b1);
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    send(64'h11223344_55667788, 64'h2002, 3'd5, 5'd7, 1'b1, 1'b1, 64'h5566, 1'b1);
    send(64'h0, 64'hDEADBEEF_00001234, 3'd0, 5'd0, 1'b0, 1'b1, 64'hDEADBEEF_00001234, 1'b0);
    send(DW, 64'h3, 3'd1, 5'd1, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFCCDD, 1'b1);
    send(DW, 64'h6, 3'd2, 5'd2, 1'b1, 1'b1, 64'hFFFFFFFF_8899AABB, 1'b1);
    send(DW, 64'h0, 3'd6, 5'd3, 1'b1, 1'b1, 64'h00000000_CCDDEEFF, 1'b1);
    send(DW, 64'h5, 3'd3, 5'd4, 1'b1, 1'b1, DW, 1'b1);
    send(DW, 64'h7, 3'd4, 5'd6, 1'b1, 1'b1, 64'h88, 1'b1);
    send(DW, 64'h01234567_89ABCDEF, 3'd0, 5'd8, 1'b0, 1'b1, 64'h01234567_89ABCDEF, 1'b1);
    drain();
    chk("retired_9", 64'(retired), 64'd9);
    chk("empty_out_valid", 64'(out_valid), 64'd0);
    chk("empty_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("empty_hold_data", 64'(wb_data), 64'h01234567_89ABCDEF);
    chk("empty_hold_rd", 64'(wb_rd), 64'd8);
    chk("empty_hold_we", 64'(wb_regwrite), 64'd1);
    @(posedge clk); #1;

    // Stall: A to main, B to skid, C refused until WB drains.
    out_ready = 1'b0;
    send(64'h0, 64'hA, 3'd0, 5'd10, 1'b0, 1'b1, 64'hA, 1'b1);
    send(64'h0, 64'hB, 3'd0, 5'd11, 1'b0, 1'b1, 64'hB, 1'b1);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_head_A", 64'(wb_data), 64'hA);
    @(posedge clk); #1;
    result_alu_in = 64'hC; rd_in = 5'd12; memtoreg_in = 1'b0; regwrite_in = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_refuse_C", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(64'h0, 64'hC, 3'd0, 5'd12, 1'b0, 1'b1, 64'hC, 1'b1);
    drain();
    chk("retired_12", 64'(retired), 64'd12);
    @(posedge clk); #1;

    // Flush with both entries full, a pending input and a same-cycle WB fire.
    out_ready = 1'b0;
    send(64'h0, 64'hD, 3'd0, 5'd13, 1'b0, 1'b1, 64'hD, 1'b1);
    send(64'h0, 64'hE, 3'd0, 5'd14, 1'b0, 1'b1, 64'hE, 1'b1);
    result_alu_in = 64'hF; rd_in = 5'd15; in_valid = 1'b1;
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_retired", 64'(retired), 64'd12);
    @(posedge clk); #1;

    // Flush with one entry and an input that would otherwise be accepted.
    out_ready = 1'b0;
    send(64'h0, 64'h6, 3'd0, 5'd16, 1'b0, 1'b1, 64'h6, 1'b1);
    result_alu_in = 64'h7; rd_in = 5'd17; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_drop_out_valid", 64'(out_valid), 64'd0);
    end
    chk("flush2_retired", 64'(retired), 64'd12);
    @(posedge clk); #1;

    // Five more fires: 17 total wraps a 4-bit counter to 1.
    for (int i = 0; i < 5; i++) begin
      logic [63:0] v;
      v = 64'h100 + 64'(i);
      send(64'h0, v, 3'd0, 5'(20 + i), 1'b0, 1'b1, v, 1'b1);
    end
    drain();
    chk("retired_wrap", 64'(retired), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memwb_elastic_reg.md
Name: memwb_elastic_reg

Overview:
- Parametrised MEM/WB pipeline boundary with a valid/ready handshake on both sides.
- A 2-entry buffer (main plus skid) lets WB stall without combinational ready paths back into MEM.
- Performs load-data alignment and sign/zero extension, and selects the final writeback value before capture.
- Provides flush, x0-write suppression, WB-to-EX forwarding outputs and a retired-instruction counter.
- Sits between the data-memory stage and the register-file write port.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- RA_W, 5, register address width.
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  block can accept; registered.
- read_data_in  in  XLEN  raw memory read word.
- result_alu_in  in  XLEN  ALU result; its low log2(XLEN/8) bits are the load byte offset.
- ld_funct3_in  in  3  load type (LB/LH/LW/LD/LBU/LHU/LWU encoding).
- rd_in  in  RA_W  destination register.
- memtoreg_in  in  1  select load data for writeback.
- regwrite_in  in  1  write enable.
- flush  in  1  kill all buffered entries.
- out_valid  out  1  WB entry valid.
- out_ready  in  1  WB consumes the entry this cycle.
- wb_data  out  XLEN  final writeback value.
- wb_rd  out  RA_W  writeback register.
- wb_regwrite  out  1  qualified write enable.
- fwd_valid  out  1  equals out_valid & wb_regwrite, for the forwarding unit.
- retired  out  RET_W  count of instructions consumed by WB.

Behaviour:
- Reset: all outputs are 0, including in_ready, and both entries are invalid. in_ready rises the cycle after reset deasserts. Reset mid-transfer drops all data.
- Capture value: wb_data = memtoreg_in ? ext : result_alu_in.
  - ext selects the byte/half/word at the offset and sign- or zero-extends it per funct3.
  - LD is illegal when XLEN=32 and is treated as LW.
  - funct3 is ignored when memtoreg_in=0.
- Misaligned half/word: the offset is truncated to natural alignment; no trap.
- wb_regwrite = regwrite_in & (rd_in != 0), evaluated at capture.
- Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
- Main holds the head entry.
  - If main is empty or the output fires, an input fire loads main.
  - Otherwise the input fire goes to skid.
  - When main fires and skid is valid, skid moves to main; any input that cycle goes to skid.
- in_ready(next) = !skid_valid(next). Latency MEM to WB is 1 cycle when unstalled.
- Full: with main and skid both valid, in_ready=0 and inputs are ignored.
- Empty: out_valid=0; wb_data, wb_rd and wb_regwrite hold their last values, but fwd_valid=0.
- Flush (priority below reset):
  - Next cycle, both entries are invalid and any same-cycle input is dropped.
  - retired does not count a same-cycle output fire.
  - in_ready=1 next cycle.
- retired increments by 1 on each output fire (not on flush) and wraps modulo 2^RET_W.
- Entry payload order is preserved strictly FIFO.

Decomposition:
- Shared package holds load funct3 localparams (LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6) and the entry struct {data, rd, regwrite}.
- One sub-module, load_align_ext: combinational alignment plus extension, parametrised by XLEN.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0 during reset; in_ready=1 one cycle after release; retired=0.
- LB, memtoreg=1, data=0x00000000_0000_80FF, alu=0x1001 (offset 1), rd=5, out_ready=1 → 1 cycle later wb_data=0xFFFF_FFFF_FFFF_FF80, wb_rd=5, fwd_valid=1.
- LHU at offset 2 of data 0x1122_3344_5566_7788 → wb_data=0x5566. ALU op with regwrite=1, rd=0 → wb_regwrite=0, fwd_valid=0.
- Stall: out_ready=0, stream A, B, C → A in main, B in skid, in_ready=0, C not accepted. Raise out_ready → output order A, B, C; retired increments by 3.
- Flush with main and skid full plus a new in_valid → next cycle out_valid=0, in_ready=1, retired unchanged, the dropped entry never appears.
- RET_W=4 with 17 output fires → retired=1 (wrap).
